aes_round_ctrl: RTL and testbench

Sequencing controller for the byte-serial iterative AES core. It drives the 5-to-1 state write mux select, the write enable, and the read/write byte addresses and bank select of the double-banked 16-byte state store. It steps the core through load, initial AddRoundKey, NR rounds and output. It sits between the host byte stream (valid/ready) and the AES datapath, and exports the round index to the key schedule.

---
 rtl/aes_round_ctrl.sv | 88 ++++++++
 tb/tb_aes_round_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencing controller for the byte-serial iterative AES core.
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_start                 begin a block (sampled only when idle)
//   i_in_valid, o_in_ready  plaintext byte handshake (ready only while loading)
//   o_out_valid, i_out_ready ciphertext byte handshake (valid only while outputting)
//   o_wr_sel, o_wr_en, o_wr_addr  state store write mux select, strobe, byte index
//   o_rd_addr, o_bank       state store read byte index and read bank (writes go to ~bank)
//   o_round                 round index for the key schedule
//   o_busy, o_done          not-idle flag, one-cycle pulse after the last output byte
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  output logic       o_busy,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [2:0] o_wr_sel,
  output logic       o_wr_en,
  output logic [3:0] o_wr_addr,
  output logic [3:0] o_rd_addr,
  output logic       o_bank,
  output logic [3:0] o_round,
  output logic       o_done
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARK0, S_SUB, S_MIX, S_ARK, S_OUT} state_t;
  state_t     r_state, w_next;
  logic [3:0] r_k, r_round;
  logic       r_bank, r_done;
  logic       w_step, w_last, w_more;
  logic [1:0] w_shift_col;
  assign w_step = r_state == S_LOAD ? i_in_valid :
                  r_state == S_OUT  ? i_out_ready :
                  r_state != S_IDLE;
  assign w_last = w_step && r_k == 4'd15;
  assign w_more = r_round < 4'(NR);
  // ShiftRows folded into the read: byte (r,c) comes from column (c+r) mod 4
  assign w_shift_col = r_k[3:2] + r_k[1:0];
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_start ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = w_last ? S_ARK0 : S_LOAD;
      S_ARK0:  w_next = w_last ? S_SUB : S_ARK0;
      S_SUB:   w_next = w_last ? (w_more ? S_MIX : S_ARK) : S_SUB;
      S_MIX:   w_next = w_last ? S_ARK : S_MIX;
      S_ARK:   w_next = w_last ? (w_more ? S_SUB : S_OUT) : S_ARK;
      S_OUT:   w_next = w_last ? S_IDLE : S_OUT;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_round <= '0;
      r_bank  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= r_state == S_OUT && w_last;
      if (r_state == S_IDLE) r_k <= '0;
      else if (w_step) r_k <= r_k + 4'd1;
      if (r_state == S_IDLE && i_start) r_round <= '0;
      else if (r_state == S_ARK0 && w_last) r_round <= 4'd1;
      else if (r_state == S_ARK && w_last && w_more) r_round <= r_round + 4'd1;
      if (w_last && r_state != S_OUT) r_bank <= ~r_bank;
    end
  end
  assign o_busy      = r_state != S_IDLE;
  assign o_in_ready  = r_state == S_LOAD;
  assign o_out_valid = r_state == S_OUT;
  assign o_wr_sel    = r_state == S_LOAD ? 3'd1 :
                       r_state == S_SUB  ? 3'd2 :
                       r_state == S_MIX  ? 3'd3 :
                       (r_state == S_ARK0 || r_state == S_ARK) ? 3'd4 : 3'd0;
  assign o_wr_en     = r_state == S_LOAD ? i_in_valid :
                       r_state inside {S_ARK0, S_SUB, S_MIX, S_ARK};
  assign o_wr_addr   = r_k;
  assign o_rd_addr   = r_state == S_SUB ? {w_shift_col, r_k[1:0]} : r_k;
  assign o_bank      = r_bank;
  assign o_round     = r_round;
  assign o_done      = r_done;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: table vectors plus write/read scoreboards for aes_round_ctrl.
module tb_aes_round_ctrl;
  localparam int NR = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic busy, in_ready, out_valid, wr_en, bank, done;
  logic [2:0] wr_sel;
  logic [3:0] wr_addr, rd_addr, round;
  logic start4 = 1'b0, iv4 = 1'b1, or4 = 1'b1;
  logic busy4, in_ready4, out_valid4, wr_en4, bank4, done4;
  logic [2:0] wr_sel4;
  logic [3:0] wr_addr4, rd_addr4, round4;

  aes_round_ctrl #(.NR(NR)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_wr_sel(wr_sel), .o_wr_en(wr_en),
    .o_wr_addr(wr_addr), .o_rd_addr(rd_addr), .o_bank(bank),
    .o_round(round), .o_done(done));

  aes_round_ctrl #(.NR(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .o_busy(busy4),
    .i_in_valid(iv4), .o_in_ready(in_ready4), .o_out_valid(out_valid4),
    .i_out_ready(or4), .o_wr_sel(wr_sel4), .o_wr_en(wr_en4),
    .o_wr_addr(wr_addr4), .o_rd_addr(rd_addr4), .o_bank(bank4),
    .o_round(round4), .o_done(done4));

  always #5 clk = ~clk;

  typedef struct {
    int cyc, busy, irdy, ovld, wen, sel, wa, ra, rnd, bnk, dn;
  } vec_t;
  typedef struct {
    int sel, wa, ra;
  } wr_t;

  int checks = 0, errors = 0;
  int n, alt, bp, stall_cnt, n_wen, n_tog, n_sub, n_mix, n_ark, done_cyc;
  logic prev_bank;
  vec_t tbl[$];
  vec_t snap[0:1100];
  wr_t q_wr[$];
  int q_rd[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cmpf(input string name, input int cyc, input int act, input int exp);
    if (exp >= 0) chk($sformatf("c%0d_%s", cyc, name), act, exp);
  endtask

  task automatic push_block(input int nr);
    for (int k = 0; k < 16; k++) q_wr.push_back('{1, k, -1});
    for (int k = 0; k < 16; k++) q_wr.push_back('{4, k, k});
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++)
        q_wr.push_back('{2, k, (k % 4) + 4 * (((k / 4) + (k % 4)) % 4)});
      if (r < nr) for (int k = 0; k < 16; k++) q_wr.push_back('{3, k, k});
      for (int k = 0; k < 16; k++) q_wr.push_back('{4, k, k});
    end
    for (int k = 0; k < 16; k++) q_rd.push_back(k);
  endtask

  task automatic tick();
    wr_t e;
    int ea;
    in_valid = alt != 0 ? (n % 2 == 0) : 1'b1;
    out_ready = 1'b1;
    if (bp != 0 && out_valid && rd_addr == 4'd7 && stall_cnt < 5) begin
      out_ready = 1'b0;
      stall_cnt++;
    end
    #1;
    if (n <= 1100)
      snap[n] = '{n, busy, in_ready, out_valid, wr_en, wr_sel, wr_addr, rd_addr, round, bank, done};
    if (bank !== prev_bank) n_tog++;
    prev_bank = bank;
    if (in_ready) chk($sformatf("c%0d_load_wen", n), wr_en, in_valid);
    if (wr_en) begin
      n_wen++;
      if (wr_addr == 4'd0) begin
        if (wr_sel == 3'd2) n_sub++;
        if (wr_sel == 3'd3) n_mix++;
        if (wr_sel == 3'd4) n_ark++;
      end
      if (q_wr.size() > 0) begin
        e = q_wr.pop_front();
        chk($sformatf("c%0d_wr_sel", n), wr_sel, e.sel);
        chk($sformatf("c%0d_wr_addr", n), wr_addr, e.wa);
        if (e.ra >= 0) chk($sformatf("c%0d_rd_addr", n), rd_addr, e.ra);
      end else begin
        checks++;
        errors++;
        $display("FAIL c%0d_extra_write actual=sel%0d/addr%0d required=none", n, wr_sel, wr_addr);
      end
    end
    if (out_valid && out_ready) begin
      ea = q_rd.size() > 0 ? q_rd.pop_front() : -1;
      chk($sformatf("c%0d_out_rd_addr", n), rd_addr, ea);
    end
    if (out_valid && !out_ready) chk($sformatf("c%0d_stall_rd_addr", n), rd_addr, 7);
    if (done && done_cyc < 0) done_cyc = n;
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_block(input int a, input int b, input string tag, input int exp_done);
    alt = a;
    bp = b;
    stall_cnt = 0;
    n_wen = 0;
    n_tog = 0;
    n_sub = 0;
    n_mix = 0;
    n_ark = 0;
    done_cyc = -1;
    push_block(NR);
    prev_bank = bank;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    while (done_cyc < 0 && n < 2000) tick();
    tick();
    chk({tag, "_done_cycle"}, done_cyc, exp_done);
    chk({tag, "_bank_toggles"}, n_tog, 3 * NR + 1);
    chk({tag, "_wen_cycles"}, n_wen, 496);
    chk({tag, "_sub_phases"}, n_sub, NR);
    chk({tag, "_mix_phases"}, n_mix, NR - 1);
    chk({tag, "_ark_phases"}, n_ark, NR + 1);
    chk({tag, "_writes_left"}, q_wr.size(), 0);
    chk({tag, "_reads_left"}, q_rd.size(), 0);
    if (b != 0) chk({tag, "_stall_cycles"}, stall_cnt, 5);
    q_wr.delete();
    q_rd.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_sel"}, wr_sel, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_round"}, round, 0);
    chk({tag, "_bank"}, bank, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int found, dcount, dn4, busy_gap, mix4_r4, mix4;
    vec_t s;
    //   cyc busy irdy ovld wen sel wa  ra  rnd bnk dn
    tbl.push_back('{  1, 1, 1, 0, 1, 1,  0, -1,  0, 0, 0});
    tbl.push_back('{ 16, 1, 1, 0, 1, 1, 15, -1,  0, 0, 0});
    tbl.push_back('{ 17, 1, 0, 0, 1, 4,  0,  0,  0, 1, 0});
    tbl.push_back('{ 32, 1, 0, 0, 1, 4, 15, 15,  0, 1, 0});
    tbl.push_back('{ 33, 1, 0, 0, 1, 2,  0,  0,  1, 0, 0});
    tbl.push_back('{ 34, 1, 0, 0, 1, 2,  1,  5,  1, 0, 0});
    tbl.push_back('{ 35, 1, 0, 0, 1, 2,  2, 10,  1, 0, 0});
    tbl.push_back('{ 36, 1, 0, 0, 1, 2,  3, 15,  1, 0, 0});
    tbl.push_back('{ 38, 1, 0, 0, 1, 2,  5,  9,  1, 0, 0});
    tbl.push_back('{ 46, 1, 0, 0, 1, 2, 13,  1,  1, 0, 0});
    tbl.push_back('{ 47, 1, 0, 0, 1, 2, 14,  6,  1, 0, 0});
    tbl.push_back('{ 48, 1, 0, 0, 1, 2, 15, 11,  1, 0, 0});
    tbl.push_back('{ 49, 1, 0, 0, 1, 3,  0,  0,  1, 1, 0});
    tbl.push_back('{ 65, 1, 0, 0, 1, 4,  0,  0,  1, 0, 0});
    tbl.push_back('{ 81, 1, 0, 0, 1, 2,  0,  0,  2, 1, 0});
    tbl.push_back('{465, 1, 0, 0, 1, 2,  0,  0, 10, 1, 0});
    tbl.push_back('{481, 1, 0, 0, 1, 4,  0,  0, 10, 0, 0});
    tbl.push_back('{497, 1, 0, 1, 0, 0, -1,  0, 10, 1, 0});
    tbl.push_back('{504, 1, 0, 1, 0, 0, -1,  7, 10, 1, 0});
    tbl.push_back('{512, 1, 0, 1, 0, 0, -1, 15, 10, 1, 0});
    tbl.push_back('{513, 0, 0, 0, 0, 0,  0,  0, -1, 1, 1});
    tbl.push_back('{514, 0, 0, 0, 0, 0,  0,  0, -1, 1, 0});

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_block(0, 0, "nominal", 48 * NR + 33);
    foreach (tbl[i]) begin
      s = snap[tbl[i].cyc];
      cmpf("busy", tbl[i].cyc, s.busy, tbl[i].busy);
      cmpf("in_ready", tbl[i].cyc, s.irdy, tbl[i].irdy);
      cmpf("out_valid", tbl[i].cyc, s.ovld, tbl[i].ovld);
      cmpf("wr_en", tbl[i].cyc, s.wen, tbl[i].wen);
      cmpf("wr_sel", tbl[i].cyc, s.sel, tbl[i].sel);
      cmpf("wr_addr", tbl[i].cyc, s.wa, tbl[i].wa);
      cmpf("rd_addr", tbl[i].cyc, s.ra, tbl[i].ra);
      cmpf("round", tbl[i].cyc, s.rnd, tbl[i].rnd);
      cmpf("bank", tbl[i].cyc, s.bnk, tbl[i].bnk);
      cmpf("done", tbl[i].cyc, s.dn, tbl[i].dn);
    end

    run_block(1, 0, "in_stall", 48 * NR + 33 + 16);
    chk("in_stall_load_end_wen", snap[32].wen, 1);
    chk("in_stall_load_end_wa", snap[32].wa, 15);
    chk("in_stall_ark0_start_sel", snap[33].sel, 4);
    run_block(0, 1, "out_bp", 48 * NR + 33 + 5);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 1;
    found = 0;
    while (found == 0 && n < 1000) begin
      if (wr_en && wr_sel == 3'd2 && round == 4'd3 && wr_addr == 4'd6) found = 1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("abort_reached_sub_r3_k6", found, 1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_reset("abort");
    dcount = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) dcount++;
    end
    chk("abort_no_done_or_busy", dcount, 0);
    run_block(0, 0, "after_abort", 48 * NR + 33);

    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1;
    n = 1;
    dn4 = -1;
    busy_gap = 0;
    mix4_r4 = 0;
    mix4 = 0;
    while (dn4 < 0 && n < 1000) begin
      if (done4) dn4 = n;
      else if (!busy4) busy_gap++;
      if (wr_en4 && wr_sel4 == 3'd3) begin
        if (round4 == 4'd4) mix4_r4++;
        if (wr_addr4 == 4'd0) mix4++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    chk("nr4_done_cycle", dn4, 225);
    chk("nr4_busy_gaps", busy_gap, 0);
    chk("nr4_mix_in_round4", mix4_r4, 0);
    chk("nr4_mix_phases", mix4, 3);
    chk("nr4_restart_busy", busy4, 1);
    chk("nr4_restart_in_ready", in_ready4, 1);
    chk("nr4_restart_wr_addr", wr_addr4, 0);
    chk("nr4_restart_round", round4, 0);
    chk("nr4_restart_done", done4, 0);
    start4 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
